// File: rtl/board_io_pkg.sv
// Shared types and helpers for the board I/O controller: reset-stretcher
// state encoding and the counter-width function used by every counter.
package board_io_pkg;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } stretch_state_t;

    // Bits needed for a counter that must be able to hold max_val itself.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, stability counter, debounced
// level, rising-edge press pulse and press toggle (both gated by hold).
module btn_debounce
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic hold,
    output logic level,
    output logic press,
    output logic toggle
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [DB_W-1:0] cnt_q;
    logic            level_q;
    logic            press_q;
    logic            toggle_q;
    logic            differs;
    logic            accept;
    logic            accept_rise;

    assign differs     = (sync_q[1] != level_q);
    assign accept      = differs && (cnt_q == DB_LAST);
    assign accept_rise = accept && sync_q[1] && !hold;

    // NOTE: every register, including the synchroniser, is cleared by the
    // synchronous reset so an abandoned debounce leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (accept) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else if (differs) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            // Pulse lands in the same cycle the level rises.
            press_q <= accept_rise;
            if (accept_rise) begin
                toggle_q <= ~toggle_q;
            end
        end
    end

    assign level  = level_q;
    assign press  = press_q;
    assign toggle = toggle_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: reset stretcher, masked LED register and optional
// debounced buttons (enabled by defining BOARD_IO_BUTTON_EN).
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int unsigned  N_BTN           = 4,
    parameter int unsigned  DEBOUNCE_CYCLES = 16,
    parameter int unsigned  RST_HOLD_CYCLES = 1024,
    parameter int unsigned  LED_W           = 8,
    parameter logic [LED_W-1:0] LED_RESET   = '0
) (
    input  logic             original_clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             led_wr_en,
    input  logic [LED_W-1:0] led_wr_data,
    input  logic [LED_W-1:0] led_wr_mask,
    output logic             core_rst,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_toggle,
    output logic [LED_W-1:0] leds
);

    localparam int unsigned HOLD_W = cnt_width(RST_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD_CYCLES);

    if (N_BTN < 1 || N_BTN > 16) begin : g_bad_n_btn
        $error("N_BTN out of range");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (RST_HOLD_CYCLES < 1 || RST_HOLD_CYCLES > (1 << 20)) begin : g_bad_hold
        $error("RST_HOLD_CYCLES out of range");
    end

    stretch_state_t    state_q;
    stretch_state_t    state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [LED_W-1:0]  leds_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge original_clk) begin
        if (rst) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // NOTE: defaults first keep this block free of inferred latches.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            HOLD: begin
                // Counter reaches RST_HOLD_CYCLES and saturates; the
                // following edge releases the core.
                if (hold_cnt_q == HOLD_MAX) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
    end

    assign core_rst = (state_q == HOLD);

    // LED writes ignore core_rst; only the board reset clears them.
    always_ff @(posedge original_clk) begin
        if (rst) begin
            leds_q <= LED_RESET;
        end else if (led_wr_en) begin
            leds_q <= (leds_q & ~led_wr_mask) | (led_wr_data & led_wr_mask);
        end
    end

    assign leds = leds_q;

`ifdef BOARD_IO_BUTTON_EN
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (original_clk),
            .rst    (rst),
            .raw    (btn_raw[i]),
            .hold   (core_rst),
            .level  (btn_level[i]),
            .press  (btn_press[i]),
            .toggle (btn_toggle[i])
        );
    end
`else
    logic unused_btn_raw;
    assign unused_btn_raw = ^btn_raw;
    assign btn_level      = '0;
    assign btn_press      = '0;
    assign btn_toggle     = '0;
`endif

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl: reset stretch, debounce timing, press
// gating, masked LED writes; button expectations follow BOARD_IO_BUTTON_EN.
module tb_board_io_ctrl;

`ifdef BOARD_IO_BUTTON_EN
    localparam bit BTN_EN = 1'b1;
`else
    localparam bit BTN_EN = 1'b0;
`endif

    logic       original_clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       led_wr_en;
    logic [7:0] led_wr_data;
    logic [7:0] led_wr_mask;
    logic       core_rst;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_toggle;
    logic [7:0] leds;

    int n_checks = 0;
    int n_errors = 0;

    board_io_ctrl #(
        .N_BTN(4),
        .DEBOUNCE_CYCLES(4),
        .RST_HOLD_CYCLES(8),
        .LED_W(8),
        .LED_RESET(8'h00)
    ) dut (
        .original_clk (original_clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .led_wr_en    (led_wr_en),
        .led_wr_data  (led_wr_data),
        .led_wr_mask  (led_wr_mask),
        .core_rst     (core_rst),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .btn_toggle   (btn_toggle),
        .leds         (leds)
    );

    always #5 original_clk = ~original_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge original_clk);
            #1;
        end
    endtask

    // Button expectation: the given pattern when buttons exist, else zero.
    function automatic logic [3:0] bx(input logic [3:0] v);
        return BTN_EN ? v : 4'b0000;
    endfunction

    initial begin
        rst         = 1'b1;
        btn_raw     = '0;
        led_wr_en   = 1'b0;
        led_wr_data = '0;
        led_wr_mask = '0;

        // Reset held for three cycles.
        tick(3);
        check("rst_core_rst", core_rst, 1);
        check("rst_leds", leds, 8'h00);
        check("rst_level", btn_level, 0);
        check("rst_press", btn_press, 0);
        check("rst_toggle", btn_toggle, 0);

        // Release; a press on channel 2 completes while core_rst is high.
        rst        = 1'b0;
        btn_raw[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("stretch_hold", core_rst, 1);
            check("hold_press_blocked", btn_press, 0);
        end
        check("hold_level2", btn_level[2], BTN_EN);
        check("hold_toggle2", btn_toggle[2], 0);
        tick(1);
        check("stretch_release", core_rst, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("stretch_stays_low", core_rst, 0);
        end

        // Channel 0 rises while channel 2 falls in the same window.
        btn_raw[0] = 1'b1;
        btn_raw[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("db0_not_yet", btn_level[0], 0);
        end
        tick(1);
        check("db0_level", btn_level, bx(4'b0001));
        check("db0_press", btn_press, bx(4'b0001));
        check("db0_toggle", btn_toggle, bx(4'b0001));
        tick(1);
        check("db0_press_one_cycle", btn_press, 0);
        check("db0_level_held", btn_level, bx(4'b0001));
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check("db0_fall_no_press", btn_press, 0);
        end
        check("db0_fall_level", btn_level, 0);
        check("db0_fall_toggle", btn_toggle, bx(4'b0001));

        // Three-cycle glitch on channel 1 is rejected.
        btn_raw[1] = 1'b1;
        tick(3);
        btn_raw[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("glitch1_level", btn_level[1], 0);
            check("glitch1_press", btn_press[1], 0);
        end

        // Four-cycle pulse is exactly long enough to be accepted.
        btn_raw[1] = 1'b1;
        tick(4);
        btn_raw[1] = 1'b0;
        tick(2);
        check("pulse4_level", btn_level[1], BTN_EN);
        check("pulse4_press", btn_press[1], BTN_EN);
        tick(6);
        check("pulse4_fall", btn_level[1], 0);
        check("pulse4_toggle", btn_toggle, bx(4'b0011));

        // Staggered changes on channels 0 and 3 debounce independently.
        btn_raw[0] = 1'b1;
        tick(2);
        btn_raw[3] = 1'b1;
        tick(4);
        check("indep_level_a", btn_level, bx(4'b0001));
        check("indep_press_a", btn_press, bx(4'b0001));
        tick(2);
        check("indep_level_b", btn_level, bx(4'b1001));
        check("indep_press_b", btn_press, bx(4'b1000));
        check("indep_toggle", btn_toggle, bx(4'b1010));
        btn_raw = '0;
        tick(8);
        check("indep_release", btn_level, 0);

        // Masked LED writes.
        led_wr_en   = 1'b1;
        led_wr_data = 8'hFF;
        led_wr_mask = 8'h0F;
        tick(1);
        check("led_wr1", leds, 8'h0F);
        led_wr_data = 8'h00;
        led_wr_mask = 8'h03;
        tick(1);
        check("led_wr2", leds, 8'h0C);
        led_wr_en   = 1'b0;
        led_wr_data = 8'hFF;
        led_wr_mask = 8'hFF;
        tick(1);
        check("led_hold", leds, 8'h0C);

        // Reset mid-debounce of channel 3, with a concurrent LED write.
        btn_raw[3] = 1'b1;
        tick(3);
        rst       = 1'b1;
        led_wr_en = 1'b1;
        tick(1);
        check("rst_wr_leds", leds, 8'h00);
        check("rst_wr_core_rst", core_rst, 1);
        check("rst_mid_level", btn_level, 0);
        check("rst_mid_toggle", btn_toggle, 0);
        rst       = 1'b0;
        led_wr_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("rst_mid_no_residual", btn_level[3], 0);
            check("rst_mid_no_press", btn_press[3], 0);
        end
        tick(1);
        check("rst_mid_fresh_level", btn_level[3], BTN_EN);
        check("rst_mid_fresh_press", btn_press[3], 0);
        check("rst_mid_core_rst", core_rst, 1);

        // LED write accepted while core_rst is still high.
        led_wr_en   = 1'b1;
        led_wr_data = 8'hA5;
        led_wr_mask = 8'hF0;
        tick(1);
        check("led_wr_in_hold", leds, 8'hA0);
        check("led_wr_in_hold_rst", core_rst, 1);
        led_wr_en = 1'b0;
        tick(1);
        check("stretch2_hold", core_rst, 1);
        tick(1);
        check("stretch2_release", core_rst, 0);

        // Fresh press on channel 3 now reaches the outputs.
        btn_raw[3] = 1'b0;
        tick(6);
        check("ch3_fall", btn_level[3], 0);
        btn_raw[3] = 1'b1;
        tick(6);
        check("ch3_press", btn_press[3], BTN_EN);
        check("ch3_toggle", btn_toggle[3], BTN_EN);
        check("ch3_leds_kept", leds, 8'hA0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/board_io_ctrl.md
BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of button channels (1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required to accept a button change (2..65535).
REQ-003 SHALL have parameter RST_HOLD_CYCLES, default 1024: cycles core_rst stays high after rst releases (1..2^20).
REQ-004 SHALL have parameter LED_W, default 8: LED register width.
REQ-005 SHALL have parameter LED_RESET, default 0: LED register reset value.
REQ-006 SHALL have port original_clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port btn_raw, input, N_BTN: asynchronous raw button inputs.
REQ-009 SHALL have port led_wr_en, input, 1: LED write strobe.
REQ-010 SHALL have port led_wr_data, input, LED_W: LED write data.
REQ-011 SHALL have port led_wr_mask, input, LED_W: per-bit write enable.
REQ-012 SHALL have port core_rst, output, 1: stretched reset to the core.
REQ-013 SHALL have port btn_level, output, N_BTN: debounced button levels.
REQ-014 SHALL have port btn_press, output, N_BTN: one-cycle pulse on debounced rising edge.
REQ-015 SHALL have port btn_toggle, output, N_BTN: flips on each btn_press.
REQ-016 SHALL have port leds, output, LED_W: registered LED drive.

Function
REQ-017 Reset stretcher SHALL be a two-state FSM: HOLD (core_rst=1, counter running), RUN (core_rst=0).
REQ-018 HOLD->RUN SHALL occur exactly RST_HOLD_CYCLES edges after the first edge sampling rst=0; rst=1 in any state forces HOLD with counter cleared.
REQ-019 Stretch counter SHALL be $clog2(RST_HOLD_CYCLES+1) bits and SHALL saturate, never wrap.
REQ-020 Each btn_raw bit SHALL pass a two-flop synchroniser before debouncing.
REQ-021 Per channel, counter SHALL increment each edge synchronised input differs from btn_level, clear when equal; on reaching DEBOUNCE_CYCLES, btn_level SHALL take the new value and counter clear.
REQ-022 A clean btn_raw step SHALL appear on btn_level exactly DEBOUNCE_CYCLES+2 cycles later; pulses shorter than DEBOUNCE_CYCLES cycles SHALL cause no change.
REQ-023 btn_press SHALL be high for exactly one cycle, the cycle btn_level goes 0->1; no output on 1->0.
REQ-024 While core_rst=1, btn_press SHALL be forced 0 and btn_toggle SHALL hold; btn_level keeps tracking.
REQ-025 On led_wr_en=1, leds SHALL update next edge to (leds & ~led_wr_mask) | (led_wr_data & led_wr_mask); otherwise hold.
REQ-026 LED writes SHALL be accepted independent of core_rst; rst=1 wins over a simultaneous write.
REQ-027 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each debounce on their own schedule.

Reset
REQ-028 On rst=1 edge: FSM=HOLD, core_rst=1, stretch counter=0, synchronisers=0, debounce counters=0, btn_level=0, btn_press=0, btn_toggle=0, leds=LED_RESET.
REQ-029 rst asserted mid-debounce or mid-stretch SHALL abandon that operation with no residual pulse after release.

Configuration
REQ-030 Macro BOARD_IO_BUTTON_EN defined: synchronisers, debouncers, btn_press, btn_toggle implemented per REQ-020..024.
REQ-031 Macro BOARD_IO_BUTTON_EN undefined: no button logic; btn_level, btn_press, btn_toggle tied 0; btn_raw ignored; stretcher and LEDs unchanged.

Structure
REQ-032 Package board_io_pkg SHALL hold the FSM state enum (HOLD, RUN) and the counter-width helper function.
REQ-033 One sub-module btn_debounce (one channel: synchroniser, counter, level, edge pulse) SHALL be instantiated N_BTN times via generate.

Verification (N_BTN=4, DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=8, LED_W=8)
REQ-034 rst high 3 cycles then low -> core_rst high through 8 edges after release, low on the 9th cycle, stays low.
REQ-035 btn_raw[0] 0->1 held -> btn_level[0]=1 exactly 6 cycles later, btn_press[0] one cycle, btn_toggle[0]=1.
REQ-036 btn_raw[1] high 3 cycles then low -> btn_level[1], btn_press[1] stay 0.
REQ-037 Press on btn_raw[2] completing during core_rst=1 -> btn_level[2]=1, btn_press[2]=0, btn_toggle[2]=0.
REQ-038 leds=0x00; write data 0xFF mask 0x0F -> 0x0F; write data 0x00 mask 0x03 -> 0x0C; rst with concurrent write -> 0x00.
REQ-039 rst pulsed mid-debounce of btn_raw[3] -> no btn_press[3] after release until a fresh full debounce completes.
